// File: rtl/normalize_round.sv
// rtl/normalize_round.sv - post-add normalizer, round-to-nearest-even and IEEE-754 packer
// Three-stage elastic pipeline: S1 leading-zero detect, S2 shift/exponent adjust, S3 round/pack.
module normalize_round #(
   parameter int N   = 23,
   parameter int EXP = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP-1:0]   in_exp,
   input  logic [N+1:0]     in_mant,
   input  logic             in_r,
   input  logic             in_s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EXP+N:0]   out_result,
   output logic             out_overflow,
   output logic             out_underflow
);
   localparam int LW = $clog2(N + 2);
   localparam int EW = EXP + 2;
   localparam logic signed [EW-1:0] EXP_INF = {2'b00, {EXP{1'b1}}};

   logic s1_load, s2_load, s3_load;

   logic           s1_valid, s1_sign, s1_r, s1_s, s1_zero;
   logic [EXP-1:0] s1_exp;
   logic [N+1:0]   s1_mant;
   logic [LW-1:0]  s1_lzc;

   logic                 s2_valid, s2_sign, s2_r, s2_s, s2_zero;
   logic signed [EW-1:0] s2_exp;
   logic [N:0]           s2_mant;

   assign s3_load  = !out_valid | out_ready;
   assign s2_load  = !s2_valid | s3_load;
   assign s1_load  = !s1_valid | s2_load;
   assign in_ready = s1_load;

   // Highest set bit wins; an all-zero field reports N+1 so R can be pulled up to the hidden bit.
   logic [LW-1:0] lzc;
   always_comb begin
      lzc = LW'(N + 1);
      for (int i = 0; i <= N; i++)
         if (in_mant[i]) lzc = LW'(N - i);
   end

   logic [N+1:0]         shifted;
   logic [N:0]           s2_mant_d;
   logic                 s2_r_d, s2_s_d;
   logic signed [EW-1:0] s2_exp_d;
   always_comb begin
      shifted = {s1_mant[N:0], s1_r} << s1_lzc;
      if (s1_mant[N+1]) begin
         s2_mant_d = s1_mant[N+1:1];
         s2_r_d    = s1_mant[0];
         s2_s_d    = s1_r | s1_s;
         s2_exp_d  = {2'b00, s1_exp} + EW'(1);
      end else begin
         // R rides along as bit -1 of the left shift; zeros follow it, so R' ends up 0 whenever lzc>0.
         {s2_mant_d, s2_r_d} = shifted;
         s2_s_d    = s1_s;
         s2_exp_d  = {2'b00, s1_exp} - {{(EW-LW){1'b0}}, s1_lzc};
      end
   end

   logic                 round_up, ovf_d, unf_d;
   logic [N:0]           frac_sum;
   logic signed [EW-1:0] exp_f;
   logic [EXP+N:0]       result_d;
   always_comb begin
      round_up = s2_r & (s2_s | s2_mant[0]);
      frac_sum = {1'b0, s2_mant[N-1:0]} + {{N{1'b0}}, round_up};
      exp_f    = s2_exp + {{(EW-1){1'b0}}, frac_sum[N]};
      result_d = {s2_sign, {(EXP+N){1'b0}}};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (!s2_zero) begin
         // A missing hidden bit means only sticky residue survived; too small to represent.
         if (!s2_mant[N] || exp_f <= 0) begin
            unf_d = 1'b1;
         end else if (exp_f >= EXP_INF) begin
            result_d = {s2_sign, {EXP{1'b1}}, {N{1'b0}}};
            ovf_d    = 1'b1;
         end else begin
            result_d = {s2_sign, exp_f[EXP-1:0], frac_sum[N-1:0]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_sign       <= 1'b0;
         s1_exp        <= '0;
         s1_mant       <= '0;
         s1_r          <= 1'b0;
         s1_s          <= 1'b0;
         s1_zero       <= 1'b0;
         s1_lzc        <= '0;
         s2_valid      <= 1'b0;
         s2_sign       <= 1'b0;
         s2_exp        <= '0;
         s2_mant       <= '0;
         s2_r          <= 1'b0;
         s2_s          <= 1'b0;
         s2_zero       <= 1'b0;
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_sign <= in_sign;
               s1_exp  <= in_exp;
               s1_mant <= in_mant;
               s1_r    <= in_r;
               s1_s    <= in_s;
               s1_zero <= (in_mant == '0) & !in_r & !in_s;
               s1_lzc  <= lzc;
            end
         end
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_sign <= s1_sign;
               s2_exp  <= s2_exp_d;
               s2_mant <= s2_mant_d;
               s2_r    <= s2_r_d;
               s2_s    <= s2_s_d;
               s2_zero <= s1_zero;
            end
         end
         if (s3_load) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
               out_result    <= result_d;
               out_overflow  <= ovf_d;
               out_underflow <= unf_d;
            end
         end
      end
   end
endmodule

// File: tb/tb_normalize_round.sv
// tb/tb_normalize_round.sv - directed vector bench for normalize_round
module tb_normalize_round;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_sign, in_r, in_s;
   logic [7:0]  in_exp;
   logic [24:0] in_mant;
   logic        out_valid, out_ready, out_overflow, out_underflow;
   logic [31:0] out_result;

   normalize_round #(.N(23), .EXP(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_r(in_r), .in_s(in_s),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] mant;
      logic        r;
      logic        s;
      logic [31:0] result;
      logic        ovf;
      logic        unf;
   } vec_t;

   typedef struct {
      logic [31:0] result;
      logic        ovf;
      logic        unf;
   } exp_t;

   vec_t vecs[16];
   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   int   out_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Output monitor: scoreboard pop on each handshake, hold check while stalled.
   logic        held_valid = 1'b0;
   logic [33:0] held_word;
   always @(negedge clk) begin
      if (rst) begin
         held_valid = 1'b0;
      end else begin
         if (held_valid && out_valid)
            check("stall_stable", {30'd0, out_result, out_overflow, out_underflow}, {30'd0, held_word});
         if (out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_beat: got %h required none", out_result);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("beat", {30'd0, out_result, out_overflow, out_underflow},
                     {30'd0, e.result, e.ovf, e.unf});
            end
         end
         held_valid = out_valid && !out_ready;
         held_word  = {out_result, out_overflow, out_underflow};
      end
   end

   task automatic send(input vec_t v);
      int n = 0;
      in_valid = 1'b1;
      in_sign  = v.sign;
      in_exp   = v.exp;
      in_mant  = v.mant;
      in_r     = v.r;
      in_s     = v.s;
      exp_q.push_back('{v.result, v.ovf, v.unf});
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $display("FAIL accept_timeout: got in_ready 0 required 1");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int lat;
      int acc;
      int acc_at_fall;
      int snap;
      logic fell;

      vecs[0]  = '{1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 8'd127, 25'h0000001, 1'b0, 1'b0, 32'h34000000, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 8'd127, 25'h0FFFFFF, 1'b1, 1'b0, 32'h40000000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 8'd127, 25'h0800000, 1'b1, 1'b0, 32'h3F800000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 8'd127, 25'h0800000, 1'b1, 1'b1, 32'h3F800001, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'd254, 25'h1000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 8'd5,   25'h0000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 8'd127, 25'h0000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'd127, 25'h1000003, 1'b0, 1'b0, 32'h40000002, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 8'd127, 25'h0000000, 1'b1, 1'b0, 32'h33800000, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 8'd130, 25'h0C00000, 1'b0, 1'b0, 32'hC1400000, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 8'd0,   25'h0800000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 8'd254, 25'h0FFFFFF, 1'b1, 1'b0, 32'h7F800000, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 8'd127, 25'h0400000, 1'b1, 1'b0, 32'h3F000001, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 8'd1,   25'h0400000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 8'd253, 25'h1800000, 1'b0, 1'b0, 32'h7F400000, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
      in_r = 1'b0; in_s = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_result", 64'(out_result), 64'd0);
      check("reset_flags", 64'({out_overflow, out_underflow}), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);

      // Single beat latency
      @(posedge clk); #1;
      send(vecs[0]);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'd3);
      drain();

      // Whole table back to back at full throughput
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) send(vecs[i]);
      drain();

      // Backpressure: six beats, output stalled for the first seven cycles
      @(posedge clk); #1;
      acc = 0; acc_at_fall = -1; fell = 1'b0;
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(vecs[i + 2]);
         end
         begin
            repeat (7) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               if (in_valid && !in_ready && !fell) begin
                  fell = 1'b1;
                  acc_at_fall = acc;
               end
               if (in_valid && in_ready) acc++;
            end
         end
      join
      check("in_ready_fell", 64'(fell), 64'd1);
      check("held_before_fall", 64'(acc_at_fall), 64'd3);
      drain();

      // Reset with two beats in flight
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(vecs[1]);
      send(vecs[3]);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_result", 64'(out_result), 64'd0);
      exp_q.delete();
      snap = out_count;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      repeat (8) @(posedge clk);
      check("no_stale_beats", 64'(out_count - snap), 64'd0);
      #1;
      send(vecs[10]);
      drain();
      check("post_rst_count", 64'(out_count - snap), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
